// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder.
package mem_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

endpackage

// File: rtl/mem_array.sv
// Single-port word storage; read data is registered on re, contents never reset.
module mem_array
  import mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Commit write data; storage has no reset.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
  end

  // Read register only; clears so the read port powers up at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  dout <= '0;
    else if (re) dout <= mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the MAR/MDR interface: accepts one word request,
// waits WAIT_CYCLES+1 edges, then completes with a one-cycle mem_ready.
// Optional build macro MEM_ADDR_CHECK_EN flags nonzero mar_in upper bits as
// out of range (no storage or Mdatain update, err with mem_ready).
module mem_responder
  import mem_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [31:0]       mar_in,
  input  logic [DATA_W-1:0] mdr_in,
  input  logic              read,
  input  logic              write,
  output logic [DATA_W-1:0] Mdatain,
  output logic              mem_ready,
  output logic              busy,
  output logic              err
);

  state_t            state, state_nxt;
  logic [3:0]        cnt;
  logic              op_q, oor_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  logic accept, both, resp_go, oor_in;
  logic cur_op, cur_oor;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_data;

  assign both    = read & write;
  assign accept  = (state == IDLE) && (read ^ write);
  assign resp_go = (state_nxt == RESP);

`ifdef MEM_ADDR_CHECK_EN
  assign oor_in = |mar_in[31:ADDR_W];
`else
  logic unused_hi;
  assign unused_hi = ^mar_in[31:ADDR_W];
  assign oor_in    = 1'b0;
`endif

  // With zero wait states RESP is entered on the acceptance edge itself,
  // so the storage access must see the live inputs instead of the latches.
  assign cur_op   = (state == IDLE) ? (write ? OP_WRITE : OP_READ) : op_q;
  assign cur_oor  = (state == IDLE) ? oor_in : oor_q;
  assign cur_addr = (state == IDLE) ? mar_in[ADDR_W-1:0] : addr_q;
  assign cur_data = (state == IDLE) ? mdr_in : data_q;

  // Next-state: IDLE -> WAIT (or RESP) on a single request, WAIT until count
  // exhausted, RESP always returns to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT: if (cnt == 4'd0) state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, request latches, wait counter and the err pulse.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state  <= IDLE;
      cnt    <= '0;
      op_q   <= OP_READ;
      oor_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      err    <= 1'b0;
    end else begin
      state <= state_nxt;
      err   <= ((state == IDLE) && both) || (resp_go && cur_oor);
      if (accept) begin
        op_q   <= write ? OP_WRITE : OP_READ;
        oor_q  <= oor_in;
        addr_q <= mar_in[ADDR_W-1:0];
        data_q <= mdr_in;
        cnt    <= 4'(WAIT_CYCLES);
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  assign mem_ready = (state == RESP);
  assign busy      = (state != IDLE);

  mem_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_array (
    .clk  (clk),
    .rst_n(clr),
    .we   (resp_go && cur_op == OP_WRITE && !cur_oor),
    .re   (resp_go && cur_op == OP_READ  && !cur_oor),
    .addr (cur_addr),
    .din  (cur_data),
    .dout (Mdatain)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with WAIT_CYCLES=2.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] mar_in = '0;
  logic [31:0] mdr_in = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] Mdatain;
  logic        mem_ready, busy, err;

  int n_chk = 0;
  int n_pass = 0;

  mem_responder #(.DATA_W(32), .ADDR_W(9), .WAIT_CYCLES(2)) dut (
    .clk(clk), .clr(clr), .mar_in(mar_in), .mdr_in(mdr_in),
    .read(read), .write(write), .Mdatain(Mdatain),
    .mem_ready(mem_ready), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
  endtask

  // Issue one request; optionally scramble mar/mdr during WAIT.
  // lat = number of negedges after the accept edge until mem_ready (-1 = none).
  // Returns with the bench sitting in the mem_ready cycle.
  task automatic xact(input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] d, input logic scramble, output int lat);
    @(negedge clk);
    mar_in = a; mdr_in = d; read = rd; write = wr;
    @(posedge clk); #1;
    read = 1'b0; write = 1'b0;
    if (scramble) begin mar_in = 32'h0AA; mdr_in = 32'h12345678; end
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (mem_ready) begin lat = i; break; end
    end
  endtask

  // Full transaction plus completion checks.
  task automatic run(input string tag, input logic wr, input logic [31:0] a,
                     input logic [31:0] d, input logic scramble,
                     input logic [31:0] exp_md, input logic exp_err);
    int lat;
    xact(!wr, wr, a, d, scramble, lat);
    chk({tag, "_lat"}, lat, 4);
    chk({tag, "_mdat"}, Mdatain, exp_md);
    chk({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
    @(negedge clk);
    chk({tag, "_done"}, {30'b0, mem_ready, busy}, 32'h0);
  endtask

  initial begin
    logic acc;
    int lat;
    #2;
    chk("rst_out", {Mdatain[0], mem_ready, busy, err}, 4'h0);
    chk("rst_md", Mdatain, 32'h0);
    @(negedge clk); clr = 1'b1;

    // Quiet idle.
    acc = 1'b0;
    repeat (10) begin @(negedge clk); acc |= mem_ready | err | busy; end
    chk("idle_quiet", {31'b0, acc}, 32'h0);

    // Write then read back; write leaves Mdatain at 0.
    run("wr5", 1'b1, 32'h005, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0);
    run("rd5", 1'b0, 32'h005, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0);

    // Simultaneous read & write: err one cycle, never busy.
    @(negedge clk);
    mar_in = 32'h005; mdr_in = 32'h0; read = 1'b1; write = 1'b1;
    @(posedge clk); #1; read = 1'b0; write = 1'b0;
    @(negedge clk);
    chk("both_err", {30'b0, err, busy}, 32'h2);
    @(negedge clk);
    chk("both_clr", {30'b0, err, busy}, 32'h0);
    run("both_rd", 1'b0, 32'h005, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0);

    // Inputs changed during WAIT must not affect the latched request.
    run("pre_aa", 1'b1, 32'h0AA, 32'hCAFEF00D, 1'b0, 32'hDEADBEEF, 1'b0);
    run("hold_wr", 1'b1, 32'h033, 32'hA5A5A5A5, 1'b1, 32'hDEADBEEF, 1'b0);
    run("hold_rd33", 1'b0, 32'h033, 32'h0, 1'b0, 32'hA5A5A5A5, 1'b0);
    run("hold_rdaa", 1'b0, 32'h0AA, 32'h0, 1'b0, 32'hCAFEF00D, 1'b0);

    // Reset during WAIT aborts the write and clears outputs at once.
    run("pre_10", 1'b1, 32'h010, 32'h22222222, 1'b0, 32'hCAFEF00D, 1'b0);
    @(negedge clk);
    mar_in = 32'h010; mdr_in = 32'h11111111; write = 1'b1;
    @(posedge clk); #1; write = 1'b0;
    @(posedge clk); #1; clr = 1'b0;
    #1;
    chk("abort_out", {29'b0, mem_ready, busy, err}, 32'h0);
    chk("abort_md", Mdatain, 32'h0);
    @(negedge clk); clr = 1'b1;
    acc = 1'b0;
    repeat (6) begin @(negedge clk); acc |= mem_ready; end
    chk("abort_nordy", {31'b0, acc}, 32'h0);
    run("abort_rd", 1'b0, 32'h010, 32'h0, 1'b0, 32'h22222222, 1'b0);

    // Upper MAR bits set.
`ifdef MEM_ADDR_CHECK_EN
    run("oor_wr", 1'b1, 32'h205, 32'h77777777, 1'b0, 32'h22222222, 1'b1);
    run("oor_rd5", 1'b0, 32'h005, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0);
`else
    run("alias_wr", 1'b1, 32'h205, 32'h77777777, 1'b0, 32'h22222222, 1'b0);
    run("alias_rd5", 1'b0, 32'h005, 32'h0, 1'b0, 32'h77777777, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
